// File: rtl/stack_controller.sv
// Stack sequencer: owns esp and turns push/pop/store/load requests into stack memory cycles.
// Optional STACK_CTRL_HIGHWATER_EN adds a high_water output tracking the deepest stack seen.
module stack_controller #(
  parameter logic [31:0] ESP_TOP   = 32'h0000_00FC,
  parameter logic [31:0] ESP_LIMIT = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_data,
  input  logic [31:0] op_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [31:0] esp,
  output logic [3:0]  mem_read_or_write,
  output logic        mem_write_strobe,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_stack_addr,
  input  logic [31:0] mem_stack_esp,
  input  logic [31:0] mem_stack_addr_access,
`ifdef STACK_CTRL_HIGHWATER_EN
  output logic [7:0]  high_water,
`endif
  output logic [7:0]  depth
);

  localparam logic [1:0]  OP_PUSH  = 2'b00;
  localparam logic [1:0]  OP_POP   = 2'b01;
  localparam logic [1:0]  OP_STORE = 2'b10;
  localparam logic [1:0]  OP_LOAD  = 2'b11;
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] esp_q, esp_d;
  logic [1:0]  code_q, code_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] saddr_q, saddr_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        req_err;

  // The legality of a request is decided once, at acceptance, against the current esp.
  always_comb begin
    req_err = 1'b0;
    case (op_code)
      OP_PUSH: req_err = (esp_q == ESP_LIMIT);
      OP_POP:  req_err = (esp_q == ESP_TOP);
      default: req_err = (op_addr > ADDR_MAX) || (op_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    state_d           = state_q;
    esp_d             = esp_q;
    code_d            = code_q;
    err_d             = err_q;
    wdata_d           = wdata_q;
    saddr_d           = saddr_q;
    rsp_data_d        = rsp_data_q;
    rsp_error_d       = rsp_error_q;
    op_ready          = 1'b0;
    rsp_valid         = 1'b0;
    mem_read_or_write = 4'h0;
    mem_write_strobe  = 1'b0;

    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          code_d  = op_code;
          err_d   = req_err;
          state_d = EXEC;
          if (!req_err) begin
            case (op_code)
              OP_PUSH: begin
                esp_d   = esp_q - 32'd4;
                wdata_d = op_data;
              end
              OP_STORE: begin
                wdata_d = op_data;
                saddr_d = op_addr;
              end
              OP_LOAD:  saddr_d = op_addr;
              default:  ;
            endcase
          end
        end
      end

      EXEC: begin
        rsp_error_d = err_q;
        rsp_data_d  = 32'd0;
        state_d     = RESP;
        if (!err_q) begin
          case (code_q)
            OP_PUSH: begin
              mem_read_or_write = 4'h1;
              mem_write_strobe  = 1'b1;
            end
            OP_STORE: begin
              mem_read_or_write = 4'h8;
              mem_write_strobe  = 1'b1;
            end
            OP_POP: begin
              rsp_data_d = mem_stack_esp;
              esp_d      = esp_q + 32'd4;
            end
            default: rsp_data_d = mem_stack_addr_access;
          endcase
        end
      end

      RESP: begin
        rsp_valid   = 1'b1;
        rsp_data_d  = 32'd0;
        rsp_error_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      esp_q       <= ESP_TOP;
      code_q      <= OP_PUSH;
      err_q       <= 1'b0;
      wdata_q     <= 32'd0;
      saddr_q     <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      esp_q       <= esp_d;
      code_q      <= code_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      saddr_q     <= saddr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

`ifdef STACK_CTRL_HIGHWATER_EN
  logic [7:0] hw_q;
  logic [7:0] depth_d;

  assign depth_d = 8'((ESP_TOP - esp_d) >> 2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hw_q <= 8'd0;
    end else if (depth_d > hw_q) begin
      hw_q <= depth_d;
    end
  end

  assign high_water = hw_q;
`endif

  assign esp            = esp_q;
  assign depth          = 8'((ESP_TOP - esp_q) >> 2);
  assign mem_write_data = wdata_q;
  assign mem_stack_addr = saddr_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_error      = rsp_error_q;

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Sequencer directly upstream of the stack memory; owns the stack pointer (esp) and turns push/pop/store/load requests into memory access cycles.
- Accepts one request at a time over a valid/ready handshake and drives the memory's mode code, write data, esp and address.
- Returns read data and an error flag one response cycle later.
- The stack grows downward in 4-byte words.

Parameters:
- ESP_TOP, 32'h0000_00FC: reset/empty esp value, the byte address of the first push slot plus 4.
- ESP_LIMIT, 32'h0000_0000: lowest legal esp; a push with esp == ESP_LIMIT is refused.
- MEM_BYTES, 256: memory size; address ops need op_addr <= MEM_BYTES-4.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  request present.
- op_ready  out  1  block can accept; high only in IDLE.
- op_code  in  2  00 push, 01 pop, 10 store word at op_addr, 11 load word from op_addr.
- op_data  in  32  push/store data.
- op_addr  in  32  byte address for store/load.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  pop/load result; 0 for push/store/error.
- rsp_error  out  1  overflow, underflow or bad address.
- esp  out  32  current stack pointer, feeds the memory esp input.
- mem_read_or_write  out  4  4'h1 push write, 4'h8 addressed write, 4'h0 otherwise.
- mem_write_strobe  out  1  write-enable pulse, feeds the memory write clock.
- mem_write_data  out  32  data to memory.
- mem_stack_addr  out  32  address for store/load.
- mem_stack_esp  in  32  word at esp from memory (combinational).
- mem_stack_addr_access  in  32  word at mem_stack_addr from memory (combinational).
- depth  out  8  words on stack = (ESP_TOP - esp) >> 2.

Behaviour:
- Reset (asynchronous, active-low; asserts immediately, also mid-operation):
  - State goes to IDLE; esp = ESP_TOP.
  - All other outputs 0, except op_ready = 1 after reset is released.
  - A request that was in flight is dropped; no write strobe occurs.
- State machine: IDLE -> EXEC -> RESP -> IDLE. Each request takes exactly 3 cycles; rsp_valid rises 2 cycles after the accept edge.
- IDLE:
  - op_ready = 1.
  - On op_valid & op_ready, latch op_code, op_data and op_addr, then go to EXEC.
  - A push that is legal decrements esp by 4 on the accept edge.
  - op_valid while not in IDLE is ignored; the requester holds its inputs until accepted.
- EXEC (1 cycle):
  - Legal push: mem_read_or_write = 4'h1, mem_write_data = data, mem_write_strobe = 1. The write lands at the already-decremented esp.
  - Legal store: mem_read_or_write = 4'h8, mem_stack_addr = op_addr, data on mem_write_data, strobe = 1.
  - Legal pop: capture mem_stack_esp into rsp_data; esp += 4 at the end of EXEC.
  - Legal load: mem_stack_addr = op_addr; capture mem_stack_addr_access.
  - Erroring ops: no strobe, mode 0, esp unchanged.
- RESP:
  - rsp_valid = 1 for exactly 1 cycle, with rsp_data and rsp_error valid in that cycle.
  - Cleared on return to IDLE.
- Error rules:
  - Push with esp == ESP_LIMIT is overflow.
  - Pop with esp == ESP_TOP is underflow.
  - Store/load with op_addr > MEM_BYTES-4, or op_addr[1:0] != 0, is a bad address.
  - Every error gives rsp_error = 1 and rsp_data = 0.
- Outside EXEC: mem_write_strobe = 0 and mem_read_or_write = 4'h0; mem_write_data and mem_stack_addr hold their last values.
- Arithmetic: esp is 32-bit unsigned and never wraps, because the bounds checks block it. depth is an 8-bit truncation.

Optional Feature:
- Macro: STACK_CTRL_HIGHWATER_EN.
- Defined: adds an output port high_water (8 bits), the maximum depth seen since reset.
  - Updated on the edge where depth increases.
  - Reset to 0; never decreases otherwise.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Release reset, idle 3 cycles -> esp = 32'hFC, depth = 0, op_ready = 1, rsp_valid = 0, mem_read_or_write = 0.
- Push 32'hDEAD_BEEF -> in EXEC, esp = 32'hF8, mem_read_or_write = 4'h1, strobe = 1, mem_write_data = 32'hDEAD_BEEF. Next cycle rsp_valid = 1, rsp_error = 0, depth = 1.
- Push 32'h1111_1111 then 32'h2222_2222, then pop twice, with the memory model returning the word at esp -> rsp_data = 32'h2222_2222, then 32'h1111_1111; esp back to 32'hF8.
- Pop on an empty stack (esp = 32'hFC) -> rsp_error = 1, rsp_data = 0, no strobe, esp unchanged. Push 63 words to esp = 0, then one more push -> rsp_error = 1 and esp stays 0.
- Store 32'hCAFE_0001 to op_addr 32'h40, then load 32'h40 -> EXEC shows mode 4'h8 with mem_stack_addr = 32'h40; load returns 32'hCAFE_0001. Load from 32'h42 or 32'h100 -> rsp_error = 1.
- Assert reset in the EXEC cycle of a push -> strobe drops immediately, esp = 32'hFC, and after release no rsp_valid pulse appears. With STACK_CTRL_HIGHWATER_EN defined, 3 pushes then 3 pops -> high_water = 3.
